// File: rtl/gcd_controller.sv
// gcd_controller
// Control FSM for an 8-bit subtract-and-compare GCD datapath. Runs a
// start/done handshake, steers the datapath register loads and muxes,
// counts subtraction iterations and aborts to an error state on invalid
// input, an illegal comparator code or iteration overrun.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   request a run; sampled only in IDLE
//   flag      in   datapath validity, 1 = both operands nonzero
//   a_gt_b    in   comparator A > B
//   a_eq_b    in   comparator A == B
//   a_lt_b    in   comparator A < B
//   a_sel     out  A mux: 1 = external operand, 0 = subtractor output
//   b_sel     out  B mux: 1 = external operand, 0 = subtractor output
//   a_ld      out  A register load enable
//   b_ld      out  B register load enable
//   sub_swap  out  subtractor: 0 = A-B, 1 = B-A
//   ld_out    out  result register load enable
//   busy      out  run in progress
//   done      out  one-cycle completion pulse
//   err       out  run aborted
//   iter_cnt  out  subtractions performed in the current or last run
module gcd_controller #(
    parameter int unsigned W_ITER   = 8,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flag,
    input  logic              a_gt_b,
    input  logic              a_eq_b,
    input  logic              a_lt_b,
    output logic              a_sel,
    output logic              b_sel,
    output logic              a_ld,
    output logic              b_ld,
    output logic              sub_swap,
    output logic              ld_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W_ITER-1:0] iter_cnt
);

    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_LOAD   = 8'b0000_0010,
        S_CMP    = 8'b0000_0100,
        S_SUB_A  = 8'b0000_1000,
        S_SUB_B  = 8'b0001_0000,
        S_OUTPUT = 8'b0010_0000,
        S_DONE   = 8'b0100_0000,
        S_ERROR  = 8'b1000_0000
    } state_t;

    localparam logic [W_ITER-1:0] MAX_CNT = W_ITER'(MAX_ITER);

    state_t            state_q, state_d;
    logic [W_ITER-1:0] iter_q, iter_d;
    logic              at_limit;

    assign at_limit = (iter_q == MAX_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        sub_swap = 1'b0;
        ld_out   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = flag ? S_LOAD : S_ERROR;
            end
            S_LOAD: begin
                a_sel   = 1'b1;
                b_sel   = 1'b1;
                a_ld    = 1'b1;
                b_ld    = 1'b1;
                busy    = 1'b1;
                iter_d  = '0;
                state_d = S_CMP;
            end
            S_CMP: begin
                busy = 1'b1;
                // Only one-hot comparator codes are legal; anything else aborts.
                case ({a_gt_b, a_eq_b, a_lt_b})
                    3'b010:  state_d = S_OUTPUT;
                    3'b100:  state_d = at_limit ? S_ERROR : S_SUB_A;
                    3'b001:  state_d = at_limit ? S_ERROR : S_SUB_B;
                    default: state_d = S_ERROR;
                endcase
            end
            S_SUB_A: begin
                a_ld    = 1'b1;
                busy    = 1'b1;
                iter_d  = iter_q + W_ITER'(1);
                state_d = S_CMP;
            end
            S_SUB_B: begin
                b_ld     = 1'b1;
                sub_swap = 1'b1;
                busy     = 1'b1;
                iter_d   = iter_q + W_ITER'(1);
                state_d  = S_CMP;
            end
            S_OUTPUT: begin
                ld_out  = 1'b1;
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                err = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            // Non-one-hot encodings are unreachable; fall back to IDLE.
            default: state_d = S_IDLE;
        endcase
    end

    assign iter_cnt = iter_q;

endmodule
